// File: rtl/pipe_bp_pkg.sv
// Shared definitions for the BTB + PHT branch predictor: counter encodings,
// PHT indexing modes and PC field extraction.
package pipe_bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Word-aligned PC: the low two bits never take part in indexing.
  function automatic logic [31:0] bidx_f(input logic [31:0] pc, input int unsigned ib);
    logic [31:0] mask;
    mask = (32'd1 << ib) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [31:0] tag_f(input logic [31:0] pc, input int unsigned ib,
                                        input int unsigned tb);
    logic [31:0] mask;
    mask = (32'd1 << tb) - 32'd1;
    return (pc >> (ib + 2)) & mask;
  endfunction

  function automatic logic [1:0] sat_upd(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (cnt == ST)  ? cnt : cnt + 2'd1;
    else       nxt = (cnt == SNT) ? cnt : cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_bp_btb_gshare_pht.sv
// Pattern history table: 2-bit saturating counters, one combinational read
// port and one synchronous train port.
module bp_pht
  import pipe_bp_pkg::*;
#(
  parameter int          IDX_BITS = 4,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic [1:0]          rd_cnt_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);

  localparam int NE = 1 << IDX_BITS;

  logic [NE-1:0][1:0] ctr_q;

  assign rd_cnt_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) ctr_q[i] <= CNT_INIT;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= sat_upd(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/pipe_bp_btb_gshare.sv
// IF-stage branch predictor: direct-mapped tagged BTB plus bimodal/gshare PHT,
// trained from ID one cycle later, with a saturating mispredict counter.
module pipe_bp_btb_gshare
  import pipe_bp_pkg::*;
#(
  parameter int         IDX_BITS = 4,
  parameter int         TAG_BITS = 8,
  parameter int         GHR_BITS = 4,
  parameter int         MODE     = 0,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         PERF_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_if,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  input  logic [31:0]         upd_pc,
  input  logic [31:0]         upd_target,
  input  logic                upd_taken,
  input  logic                upd_btb,
  input  logic                upd_pdt,
  input  logic                upd_mispred,
  input  logic                flush_btb,
  output logic [GHR_BITS-1:0] ghr,
  output logic [PERF_W-1:0]   mispred_cnt
);

  localparam int NE = 1 << IDX_BITS;

  logic [NE-1:0]               vld_q;
  logic [NE-1:0][TAG_BITS-1:0] tag_q;
  logic [NE-1:0][31:0]         tgt_q;
  logic [GHR_BITS-1:0]         ghr_q, ghr_d;
  logic [PERF_W-1:0]           mcnt_q, mcnt_d;

  logic [IDX_BITS-1:0] rd_bidx, wr_bidx, rd_pidx, wr_pidx;
  logic [TAG_BITS-1:0] rd_tag, wr_tag;
  logic [1:0]          rd_cnt;

  assign rd_bidx = IDX_BITS'(bidx_f(pc_if, IDX_BITS));
  assign wr_bidx = IDX_BITS'(bidx_f(upd_pc, IDX_BITS));
  assign rd_tag  = TAG_BITS'(tag_f(pc_if, IDX_BITS, TAG_BITS));
  assign wr_tag  = TAG_BITS'(tag_f(upd_pc, IDX_BITS, TAG_BITS));

  // No history checkpointing: the GHR cannot move between lookup and training.
  generate
    if (MODE == MODE_GSHARE) begin : g_gshare
      assign rd_pidx = rd_bidx ^ IDX_BITS'(ghr_q);
      assign wr_pidx = wr_bidx ^ IDX_BITS'(ghr_q);
    end else begin : g_bimodal
      assign rd_pidx = rd_bidx;
      assign wr_pidx = wr_bidx;
    end
  endgenerate

  bp_pht #(.IDX_BITS(IDX_BITS), .CNT_INIT(CNT_INIT)) u_pht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (rd_pidx),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (upd_pdt),
    .wr_idx_i   (wr_pidx),
    .wr_taken_i (upd_taken)
  );

  assign pred_hit    = vld_q[rd_bidx] && (tag_q[rd_bidx] == rd_tag);
  assign pred_taken  = pred_hit && rd_cnt[1];
  assign pred_target = pred_hit ? tgt_q[rd_bidx] : 32'd0;
  assign ghr         = ghr_q;
  assign mispred_cnt = mcnt_q;

  always_comb begin
    ghr_d  = ghr_q;
    mcnt_d = mcnt_q;
    if (upd_pdt) ghr_d = {ghr_q[GHR_BITS-2:0], upd_taken};
    if (upd_mispred && !(&mcnt_q)) mcnt_d = mcnt_q + PERF_W'(1);
  end

  // Flush wins over a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      ghr_q  <= '0;
      mcnt_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      mcnt_q <= mcnt_d;
      if (flush_btb)    vld_q          <= '0;
      else if (upd_btb) vld_q[wr_bidx] <= 1'b1;
    end
  end

  // Tag/target storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (upd_btb && !flush_btb) begin
      tag_q[wr_bidx] <= wr_tag;
      tgt_q[wr_bidx] <= upd_target;
    end
  end

endmodule

// File: doc/pipe_bp_btb_gshare.md
Name: pipe_bp_btb_gshare

Overview:
Parametrised successor to the IF-stage branch predictor. It combines a direct-mapped, tagged BTB with a pattern history table (PHT) of 2-bit saturating counters, selectable as bimodal or gshare. It answers the IF-stage lookup in the same cycle and is trained from the ID stage one cycle later. It also counts mispredictions for performance monitoring.

Parameters:
IDX_BITS, 4, log2 of BTB/PHT entry count (16 entries).
TAG_BITS, 8, tag width stored per BTB entry.
GHR_BITS, 4, global history length; must be <= IDX_BITS.
MODE, 0, PHT indexing: 0 = bimodal, 1 = gshare.
CNT_INIT, 2'b01, PHT counter reset value (weakly not-taken).
PERF_W, 16, width of the mispredict counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
pc_if  in  32  fetch PC to look up.
pred_hit  out  1  BTB valid and tag match for pc_if.
pred_taken  out  1  pred_hit & PHT counter MSB.
pred_target  out  32  BTB target on hit, else 0.
upd_pc  in  32  PC of the resolved branch/jump (ID stage).
upd_target  in  32  resolved target address.
upd_taken  in  1  resolved direction.
upd_btb  in  1  write BTB entry for upd_pc.
upd_pdt  in  1  train PHT counter and GHR.
upd_mispred  in  1  prediction was wrong; bumps perf counter.
flush_btb  in  1  invalidate all BTB entries.
ghr  out  GHR_BITS  current global history (debug).
mispred_cnt  out  PERF_W  saturating mispredict count.

Behaviour:
- Reset (async, any time, including mid-update): all valid bits = 0, all counters = CNT_INIT, GHR = 0, mispred_cnt = 0. The prediction outputs are therefore 0 for any pc_if immediately.
- BTB index bidx = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. The BTB is always indexed by PC only.
- PHT index:
  - MODE 0: pidx = bidx.
  - MODE 1: pidx = bidx XOR zero-extended GHR.
- Lookup is purely combinational on pc_if and the current state, with zero latency.
  - pred_target = 0 when there is no hit.
- Updates are registered on the rising clk edge.
  - upd_btb: entry[bidx(upd_pc)] gets valid = 1, tag(upd_pc), upd_target. The write is unconditional; it overwrites any aliasing entry.
  - upd_pdt: the counter at pidx(upd_pc) is computed with the pre-edge GHR. It increments on upd_taken and decrements otherwise, saturating at 2'b11 and 2'b00.
  - upd_pdt also shifts the GHR: GHR <= {GHR[GHR_BITS-2:0], upd_taken}.
  - upd_mispred: mispred_cnt increments and saturates at all-ones.
- Same-cycle lookup and update of the same entry: the lookup sees the pre-update values; the new values are visible the next cycle.
- flush_btb clears all valid bits next edge and has priority over a same-cycle upd_btb. Counters, GHR and mispred_cnt are untouched.
- upd_btb and upd_pdt are independent. Either may be asserted alone, for example an unconditional jump trains the BTB only.
- Gshare consistency: the pipeline has at most one unresolved branch, so the GHR is unchanged between lookup and its update. No history checkpointing is done.

Decomposition:
- Shared package pipe_bp_pkg holds:
  - MODE_BIMODAL / MODE_GSHARE constants.
  - the 2-bit counter encodings SNT/WNT/WT/ST.
  - the index/tag extraction functions.
- One sub-module, bp_pht: an array of 2-bit saturating counters with async reset to CNT_INIT, one combinational read port and one synchronous update port. The BTB arrays and GHR stay in the top module.

Test Plan:
1. Reset, then lookup pc_if = 0x44 -> pred_hit = 0, pred_taken = 0, pred_target = 0x0, mispred_cnt = 0.
2. MODE 0: upd_pc = 0x44, upd_target = 0x100, upd_taken = 1, upd_btb = upd_pdt = 1 for one cycle; next cycle lookup 0x44 -> hit = 1, counter 01->10, taken = 1, target = 0x100.
3. Alias: after test 2, lookup 0x444 (bidx 1, tag 0x11 vs 0x01) -> hit = 0, target = 0. Then upd_btb with 0x444 -> the 0x44 lookup now misses.
4. Saturation: three taken trainings of 0x44 -> counter 11. Not-taken once -> 10, taken = 1; not-taken again -> 01, taken = 0. Four further not-taken -> stays 00.
5. MODE 1: train taken, taken, not-taken on pc 0x80 -> ghr = 4'b0110. A taken training of 0x44 then updates pidx = 1^6 = 7, not entry 1.
6. flush_btb together with upd_btb for 0x44 -> next cycle hit = 0 and the counter is retained. Assert rst mid-sequence -> all outputs return to 0 asynchronously. 2^PERF_W+3 upd_mispred pulses -> mispred_cnt = 0xFFFF.
